// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes and FSM states.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_DONE
  } state_e;

  function automatic logic size_illegal(input logic [1:0] size);
    return size == 2'b11;
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Little-endian lane extraction for loads and lane insertion for sub-word stores.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = load_word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? load_word[31:16] : load_word[15:0];
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    store_word = base_word;
    case (size)
      SZ_BYTE: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: valid/ready request port to a word-addressed memory,
// sub-word loads extended, sub-word stores done as read-modify-write.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_e             state_q, state_d;
  logic               write_q, uns_q, fault_q;
  logic [1:0]         size_q, off_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q, merge_q, rdata_q;
  logic               accept, req_fault;
  logic [31:0]        load_data, store_word;

  assign accept   = req_valid & req_ready;
  assign mem_addr = {{(32 - IDX_W){1'b0}}, idx_q};

  // Word index beyond the memory is equivalent to nonzero addr[31:IDX_W+2].
  always_comb begin
    req_fault = size_illegal(req_size)
              | ((req_size == SZ_HALF) & req_addr[0])
              | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
              | (req_addr[31:2] >= WORD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = req_fault ? ST_DONE : ST_ACCESS;
      ST_ACCESS: state_d = (write_q && size_q != SZ_WORD) ? ST_MERGE : ST_DONE;
      ST_MERGE:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_fault = resp_valid & fault_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      ST_ACCESS: begin
        if (write_q && size_q == SZ_WORD) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      ST_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = store_word;
      end
      default: ;
    endcase
    // Reset wins combinationally so a mid-operation reset never commits a write.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        fault_q <= req_fault;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        idx_q   <= req_addr[IDX_W+1:2];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state_q == ST_ACCESS) begin
        merge_q <= mem_rdata;
        if (!write_q) rdata_q <= load_data;
      end
    end
  end

  mips_lsu_lane u_lane (
    .load_word   (mem_rdata),
    .base_word   (merge_q),
    .wdata       (wdata_q),
    .size        (size_q),
    .offset      (off_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu with an attached word memory and a behavioural model.
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mips_lsu #(.MEM_WORDS(1024), .IDX_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  // Data memory: combinational read, write on clk edge; backdoor port for preload.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[9:0]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  logic [31:0] ref_mem [0:1023];
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
    bd_idx  = idx;
    bd_data = data;
    bd_we   = 1'b1;
    ref_mem[idx] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Reference: what the request should do, from the lane/fault rules in plain arithmetic.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] e_rdata, output logic e_fault,
                                output int e_lat, output int e_we);
    logic [31:0] v, mask;
    int unsigned idx, sh;
    e_fault = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
              (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
    idx = addr / 4;
    sh  = 8 * (addr % 4);
    e_rdata = 32'h0;
    e_we    = 0;
    if (e_fault) begin
      e_lat = 1;
    end else if (!wr) begin
      e_lat = 2;
      v = ref_mem[idx] >> sh;
      if (sz == 2'd0) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v - 32'h100;
      end else if (sz == 2'd1) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end
      e_rdata = v;
    end else begin
      e_lat = (sz == 2'd2) ? 2 : 3;
      e_we  = 1;
      mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
      mask  = mask << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
    end
  endfunction

  // Called at a negedge; returns at the negedge showing resp_valid (or after a bound).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic fault, output int lat,
                        output int we_cnt, output int busy_ready, output int wait_cyc);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 99; we_cnt = 0; busy_ready = 0; rdata = 'x; fault = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      if (mem_we) we_cnt++;
      if (req_ready) busy_ready++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; fault = resp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output int wait_cyc);
    logic [31:0] e_rdata;
    logic        e_fault, fault;
    int          e_lat, e_we, lat, we_cnt, busy;
    model(wr, sz, uns, addr, wd, e_rdata, e_fault, e_lat, e_we);
    do_req(wr, sz, uns, addr, wd, rdata, fault, lat, we_cnt, busy, wait_cyc);
    check({tag, "_rdata"}, rdata, e_rdata);
    check({tag, "_fault"}, {31'h0, fault}, {31'h0, e_fault});
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_we_count"}, 32'(we_cnt), 32'(e_we));
    check({tag, "_ready_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    int          wc, vcnt;

    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) bd_write(10'(i), $urandom);
    bd_write(10'd1,  32'h00DD3E35);
    bd_write(10'd2,  32'h80003AD1);
    bd_write(10'd10, 32'h00000311);

    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run("lb_0b", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, rd, wc);
    check("lb_0b_const", rd, 32'hFFFFFF80);
    run("lbu_0b", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, rd, wc);
    check("lbu_0b_const", rd, 32'h00000080);
    run("lh_06", 1'b0, 2'b01, 1'b0, 32'h06, 32'h0, rd, wc);
    check("lh_06_const", rd, 32'h000000DD);
    run("lhu_04", 1'b0, 2'b01, 1'b1, 32'h04, 32'h0, rd, wc);
    check("lhu_04_const", rd, 32'h00003E35);
    run("lw_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, wc);
    check("lw_04_const", rd, 32'h00DD3E35);
    run("sb_29", 1'b1, 2'b00, 1'b0, 32'h29, 32'h123456AB, rd, wc);
    check("sb_29_mem", mem[10], 32'h0000AB11);
    run("lw_28", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, rd, wc);
    check("lw_28_const", rd, 32'h0000AB11);

    run("flt_lw_06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, wc);
    run("flt_sh_1001", 1'b1, 2'b01, 1'b0, 32'h1001, 32'h5555, rd, wc);
    run("flt_lw_1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, wc);
    run("flt_size3", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, rd, wc);

    // Reset during the MERGE cycle of an SH: no write, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h02; req_wdata = 32'h0000BEEF;
    wc = 0;
    while (!req_ready && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mrst_merge_we", {31'h0, mem_we}, 32'h0);
    check("mrst_merge_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_ready", {31'h0, req_ready}, 32'h1);
    check("mrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("mrst_resp_rdata", resp_rdata, 32'h0);
    check("mrst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("mrst_mem_addr", mem_addr, 32'h0);
    check("mrst_mem_wdata", mem_wdata, 32'h0);
    check("mrst_mem_we", {31'h0, mem_we}, 32'h0);
    check("mrst_mem0_kept", mem[0], ref_mem[0]);
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) vcnt++;
      @(negedge clk);
    end
    check("mrst_no_resp", 32'(vcnt), 32'h0);

    run("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFEF00D, rd, wc);
    run("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, wc);
    check("b2b_lw_const", rd, 32'hCAFEF00D);
    check("b2b_accept_gap", 32'(wc), 32'h1);

    for (int n = 0; n < 80; n++) begin
      wr  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      sz  = ($urandom % 8 == 7) ? 2'b11 : 2'($urandom % 3);
      addr = 32'((($urandom % 16) << 2) | ($urandom % 4));
      if (sz == 2'b10 && $urandom % 4 != 0) addr[1:0] = 2'b00;
      if (sz == 2'b01 && $urandom % 4 != 0) addr[0] = 1'b0;
      if ($urandom % 10 == 0) addr = addr | (32'h1 << (12 + $urandom % 20));
      wd = $urandom;
      run($sformatf("rnd%0d", n), wr, sz, uns, addr, wd, rd, wc);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store unit between the MIPS execute stage and the word-addressed data memory. It acts as the memory initiator.
- Accepts byte-addressed load/store requests over a valid/ready handshake and drives the memory's word index, write data and write strobe.
- Sign- or zero-extends sub-word loads.
- Implements byte and halfword stores as read-modify-write, because the memory has only a whole-word write enable.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory.
- IDX_W, 10, word-index width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and LW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low bits are used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned, out-of-range or illegal-size request; qualified by resp_valid
- mem_addr  out  32  word index, zero-extended from IDX_W bits
- mem_wdata  out  32  word written to memory
- mem_we  out  1  memory write strobe; the memory writes on the clk edge when it is high
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- States: IDLE, ACCESS, MERGE, DONE.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, mem_addr 0, mem_wdata 0, mem_we 0.
- mem_we is forced to 0 during any cycle with reset high, including a reset asserted mid-operation. Any in-flight request is dropped with no response.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on an edge with req_valid & req_ready; all request fields are latched at that edge.
  - req_valid while not ready is ignored; the requester holds it.
- Fault check at accept. The request faults if any of the following holds:
  - req_size is 11.
  - half with addr[0] = 1.
  - word with addr[1:0] != 0.
  - addr[31:IDX_W+2] != 0.
- On fault: the next state is DONE, no memory cycle and no write occurs, and resp_fault = 1.
- IDLE -> ACCESS for a legal request. mem_addr = addr[IDX_W+1:2], held from ACCESS through MERGE.
- ACCESS:
  - Load: latch the extended lane of mem_rdata into resp_rdata, then go to DONE.
  - SW: mem_we = 1 and mem_wdata = wdata, then go to DONE.
  - SB/SH: latch mem_rdata into the merge register, then go to MERGE.
- MERGE: mem_we = 1. mem_wdata = merge register with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Then go to DONE.
- Lane rules (little-endian lanes):
  - Byte k occupies bits 8k+7:8k.
  - A half at addr[1] = 1 occupies bits 31:16.
  - Sign extension copies the lane MSB; zero extension fills with 0.
- DONE: resp_valid = 1 for exactly one cycle, then go to IDLE. req_ready returns to 1 in that IDLE cycle.
- Latency from accept edge to resp_valid cycle: fault 1, LW/SW 2, SB/SH 3.
- Throughput: one request in flight at a time. Back-to-back requests incur no gap beyond the IDLE accept cycle.
- mem_we is high only in the ACCESS cycle of SW or the MERGE cycle of SB/SH, and never in any other state.

Decomposition:
- Package mips_lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encodings ST_IDLE, ST_ACCESS, ST_MERGE, ST_DONE.
- Sub-module mips_lsu_lane, purely combinational:
  - extract(word, size, offset, unsigned) -> 32-bit load value.
  - merge(word, wdata, size, offset) -> 32-bit store word.
- The FSM and handshake remain in mips_lsu.
- The bench pairs mips_lsu with the existing data memory model.

Test Plan:
- Memory word 2 = 0x80003AD1.
  - LB at addr 0x0B -> resp_rdata 0xFFFFFF80, resp_valid 2 cycles after accept, no mem_we.
  - LBU at addr 0x0B -> 0x00000080.
- Memory word 1 = 0x00DD3E35.
  - LH at 0x06 -> 0x000000DD.
  - LHU at 0x04 -> 0x00003E35.
  - LW at 0x04 -> 0x00DD3E35.
- Memory word 10 = 0x00000311.
  - SB at addr 0x29 with wdata 0x123456AB -> memory word 10 = 0x0000AB11 after MERGE.
  - mem_we is high exactly once, resp_valid is 3 cycles after accept, and a following LW at 0x28 returns 0x0000AB11.
- Faults:
  - LW at 0x06 -> resp_fault 1 one cycle after accept, mem_we never high.
  - SH at 0x1001 -> fault.
  - LW at 0x00001000 -> fault (out of range).
  - req_size 11 -> fault.
- Reset mid-operation:
  - SH at 0x02 with wdata 0xBEEF; assert reset in the MERGE cycle -> mem_we stays 0 and no resp_valid.
  - The next cycle shows req_ready 1 and all outputs at reset values.
- Back-to-back traffic:
  - Hold req_valid for SW 0x00 = 0xCAFEF00D followed by LW 0x00 -> second request accepted the cycle after the first resp_valid.
  - LW returns 0xCAFEF00D, and req_ready is 0 throughout each request's ACCESS and DONE cycles.
